// File: rtl/sample_fifo_pkg.sv
// Shared types and defaults for the FIR input sample buffer.
package sample_fifo_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH      = 16;
   localparam int unsigned DEFAULT_AF_MARGIN  = 2;

   typedef logic [DEFAULT_DATA_WIDTH-1:0] sample_t;

   // Bit 0 = push accepted, bit 1 = pop accepted.
   typedef enum logic [1:0] {
      ACC_NONE = 2'b00,
      ACC_PUSH = 2'b01,
      ACC_POP  = 2'b10,
      ACC_BOTH = 2'b11
   } access_e;

endpackage

// File: rtl/sample_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module sample_fifo_ram
   import sample_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer feeding the decimating FIR.
// Optional SAMPLE_FIFO_STICKY_ERR_EN: overflow/underflow hold until reset instead of pulsing.
module sample_fifo
   import sample_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned DEPTH      = DEFAULT_DEPTH,
   parameter int unsigned AF_MARGIN  = DEFAULT_AF_MARGIN
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   din,
   output logic                    full,
   output logic                    almost_full,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [ADDR_W:0]  PTR_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);

   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic                  almost_full_q, almost_full_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  push, pop;
   logic                  ovf_evt, udf_evt;
   access_e               access;
   logic [DATA_WIDTH-1:0] ram_rdata;

   always_comb begin
      // A full FIFO still accepts a push when the same cycle pops.
      push    = wr_en && (!full_q || rd_en);
      pop     = rd_en && !empty_q;
      ovf_evt = wr_en && full_q && !rd_en;
      udf_evt = rd_en && empty_q;
      access  = access_e'({pop, push});

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      case (access)
         ACC_PUSH: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
         ACC_POP: begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
         end
         ACC_BOTH: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         default: ;
      endcase

      empty_d       = (wr_ptr_d == rd_ptr_d);
      full_d        = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                      (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
      almost_full_d = (count_d >= AF_LEVEL);

`ifdef SAMPLE_FIFO_STICKY_ERR_EN
      overflow_d  = overflow_q  | ovf_evt;
      underflow_d = underflow_q | udf_evt;
`else
      overflow_d  = ovf_evt;
      underflow_d = udf_evt;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   sample_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (din),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   // Gating on the reset-cleared empty flag keeps dout at 0 out of reset without clearing memory.
   assign dout        = empty_q ? '0 : ram_rdata;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = almost_full_q;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: vector table plus scoreboarded multi-cycle sequences.
module tb_sample_fifo;
   import sample_fifo_pkg::*;

   localparam int unsigned DEPTH = 16;
`ifdef SAMPLE_FIFO_STICKY_ERR_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   sample_t    din   = '0;
   logic       full, almost_full, empty, overflow, underflow;
   sample_t    dout;
   logic [4:0] count;

   int checks   = 0;
   int failures = 0;
   sample_t sb[$];

   typedef struct {
      logic    wr;
      logic    rd;
      sample_t din;
      int      exp_count;
      logic    exp_empty;
      logic    exp_full;
      sample_t exp_dout;
      logic    exp_ovf;
      logic    exp_udf;
   } vec_t;

   vec_t vecs[10];

   sample_fifo #(
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .AF_MARGIN  (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_en),
      .din         (din),
      .full        (full),
      .almost_full (almost_full),
      .rd_en       (rd_en),
      .dout        (dout),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      sb.delete();
   endtask

   function automatic vec_t mk(input logic wr, input logic rd, input sample_t d, input int c,
                               input logic e, input logic f, input sample_t q,
                               input logic ov, input logic ud);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = d; v.exp_count = c; v.exp_empty = e;
      v.exp_full = f; v.exp_dout = q; v.exp_ovf = ov; v.exp_udf = ud;
      return v;
   endfunction

   initial begin
      //        wr    rd    din   cnt e     f     dout  ovf   udf
      vecs[0] = mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      vecs[1] = mk(1'b0, 1'b1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      vecs[2] = mk(1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, STICKY);
      vecs[3] = mk(1'b1, 1'b0, 32'hA, 1, 1'b0, 1'b0, 32'hA, 1'b0, STICKY);
      vecs[4] = mk(1'b1, 1'b0, 32'hB, 2, 1'b0, 1'b0, 32'hA, 1'b0, STICKY);
      vecs[5] = mk(1'b1, 1'b1, 32'hC, 2, 1'b0, 1'b0, 32'hB, 1'b0, STICKY);
      vecs[6] = mk(1'b0, 1'b1, 32'h0, 1, 1'b0, 1'b0, 32'hC, 1'b0, STICKY);
      vecs[7] = mk(1'b0, 1'b1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, STICKY);
      vecs[8] = mk(1'b1, 1'b1, 32'h5, 1, 1'b0, 1'b0, 32'h5, 1'b0, 1'b1);
      vecs[9] = mk(1'b0, 1'b1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0, STICKY);

      // Reset state, observed while reset is still asserted.
      repeat (2) @(negedge clock);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_count", count, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         wr_en = vecs[i].wr;
         rd_en = vecs[i].rd;
         din   = vecs[i].din;
         tick();
         wr_en = 1'b0;
         rd_en = 1'b0;
         chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
         chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
         chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
         chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
         chk($sformatf("vec%0d_udf", i), underflow, vecs[i].exp_udf);
      end

      // Fill to full, then a dropped 17th push.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1;
         din   = i;
         tick();
         sb.push_back(i);
         chk($sformatf("fill%0d_count", i), count, i);
         chk($sformatf("fill%0d_af", i), almost_full, (i >= 14));
         chk($sformatf("fill%0d_full", i), full, (i == 16));
         chk($sformatf("fill%0d_dout", i), dout, sb[0]);
      end
      din = 17;
      tick();
      wr_en = 1'b0;
      chk("drop_count", count, 16);
      chk("drop_full", full, 1);
      chk("drop_dout", dout, sb[0]);
      chk("drop_ovf", overflow, 1);
      tick();
      chk("drop_ovf_after", overflow, STICKY);

      // Simultaneous push and pop on a full FIFO.
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 99;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      void'(sb.pop_front());
      sb.push_back(99);
      chk("fullrw_count", count, 16);
      chk("fullrw_full", full, 1);
      chk("fullrw_dout", dout, sb[0]);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d_dout", k), dout, sb[0]);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         void'(sb.pop_front());
      end
      chk("drain_empty", empty, 1);
      chk("drain_count", count, 0);
      chk("drain_dout", dout, 0);

      // Steady-state wrap with three entries resident.
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         wr_en = 1'b1;
         din   = i;
         tick();
         sb.push_back(i);
      end
      wr_en = 1'b0;
      chk("prime_count", count, 3);
      for (int k = 1; k <= 40; k++) begin
         chk($sformatf("wrap%0d_dout", k), dout, sb[0]);
         wr_en = 1'b1;
         rd_en = 1'b1;
         din   = k + 3;
         tick();
         void'(sb.pop_front());
         sb.push_back(k + 3);
         chk($sformatf("wrap%0d_count", k), count, 3);
         chk($sformatf("wrap%0d_flags", k), {full, almost_full, overflow, underflow, empty}, 0);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("wrapdrain%0d_dout", k), dout, sb[0]);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         void'(sb.pop_front());
      end
      chk("wrapdrain_empty", empty, 1);

      // Asynchronous reset mid-stream: flags clear with no clock edge.
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1;
         din   = 200 + i;
         tick();
      end
      chk("pre_arst_count", count, 10);
      #2 reset = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_dout", dout, 0);
      chk("arst_full", full, 0);
      wr_en = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1;
         din   = 77 + i;
         tick();
         sb.push_back(77 + i);
      end
      wr_en = 1'b0;
      chk("post_arst_count", count, 3);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("post_arst%0d_dout", k), dout, sb[0]);
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         void'(sb.pop_front());
      end
      chk("post_arst_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
